// File: rtl/apb_gpio_pkg.sv
// Register offsets shared by the APB GPIO-with-interrupt slave and its users.
package apb_gpio_pkg;

  localparam int GPIO_NREGS = 8;

  localparam logic [2:0] GPIO_OUT      = 3'd0;
  localparam logic [2:0] GPIO_DIR      = 3'd1;
  localparam logic [2:0] GPIO_IN       = 3'd2;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_IRQ_POL  = 3'd4;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd5;
  localparam logic [2:0] GPIO_OUT_SET  = 3'd6;
  localparam logic [2:0] GPIO_OUT_CLR  = 3'd7;

endpackage

// File: rtl/apb_gpio_irq_if.sv
// APB bus bundle for the GPIO slave; the master side drives the request,
// the slave side returns data, ready and error.
interface apb_gpio_irq_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              PSEL;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// Input synchronizer chain plus a one-cycle delayed copy, giving per-pin
// rising and falling edge pulses on the synchronized value.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  // Shift pins through the synchronizer; prev always follows sync so a
  // polarity change in the top never creates a false edge.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB GPIO port with direction control, atomic set/clear, synchronized
// inputs and per-pin edge interrupts (sticky W1C status, one irq line).
module apb_gpio_irq
  import apb_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_gpio_irq_if.slave    apb,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_r, dir_r, irq_en, irq_pol, irq_stat;
  logic [WIDTH-1:0] sync, rise, fall, evt, w1c, wdata, rd_val;
  logic             setup, access, mapped, wr_en;
  logic [2:0]       idx;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .gpio_i  (gpio_i),
    .sync    (sync),
    .rise    (rise),
    .fall    (fall)
  );

  assign setup   = apb.PSEL & ~apb.PENABLE;
  assign access  = apb.PSEL & apb.PENABLE;
  assign mapped  = (apb.PADDR < ADDR_W'(GPIO_NREGS));
  assign idx     = apb.PADDR[2:0];
  assign wr_en   = access & apb.PWRITE & mapped;
  assign wdata   = apb.PWDATA[WIDTH-1:0];
  assign w1c     = (wr_en && idx == GPIO_IRQ_STAT) ? wdata : '0;
  assign evt     = ((irq_pol & rise) | (~irq_pol & fall)) & ~dir_r;

  assign apb.PREADY = 1'b1;
  assign gpio_o     = out_r;
  assign gpio_oe    = dir_r;

  // Read mux; write-only and unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    case (idx)
      GPIO_OUT:      rd_val = out_r;
      GPIO_DIR:      rd_val = dir_r;
      GPIO_IN:       rd_val = sync;
      GPIO_IRQ_EN:   rd_val = irq_en;
      GPIO_IRQ_POL:  rd_val = irq_pol;
      GPIO_IRQ_STAT: rd_val = irq_stat;
      default:       rd_val = '0;
    endcase
    if (!mapped) rd_val = '0;
  end

  // Read data and error are captured in SETUP and held through ACCESS.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      apb.PRDATA  <= '0;
      apb.PSLVERR <= 1'b0;
    end else if (setup) begin
      apb.PRDATA  <= DATA_W'(rd_val);
      apb.PSLVERR <= ~mapped;
    end else if (!access) begin
      apb.PSLVERR <= 1'b0;
    end
  end

  // Control register writes commit on the edge that ends ACCESS.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      out_r   <= '0;
      dir_r   <= '0;
      irq_en  <= '0;
      irq_pol <= '0;
    end else if (wr_en) begin
      case (idx)
        GPIO_OUT:     out_r   <= wdata;
        GPIO_DIR:     dir_r   <= wdata;
        GPIO_IRQ_EN:  irq_en  <= wdata;
        GPIO_IRQ_POL: irq_pol <= wdata;
        GPIO_OUT_SET: out_r   <= out_r | wdata;
        GPIO_OUT_CLR: out_r   <= out_r & ~wdata;
        default:      ;
      endcase
    end
  end

  // Sticky status: a new edge outranks a simultaneous clear; irq follows a cycle later.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= (irq_stat & ~w1c) | evt;
      irq      <= |(irq_stat & irq_en);
    end
  end

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed bench for apb_gpio_irq: register access, set/clear, edge
// interrupt latency, W1C/set collision, masked pins, errors and reset.
module tb_apb_gpio_irq;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic [7:0] gpio_i;
  logic [7:0] gpio_o, gpio_oe;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rd;
  logic       err;
  logic [7:0] pre_o;

  apb_gpio_irq_if #(.ADDR_W(8), .DATA_W(8)) apb ();

  apb_gpio_irq #(
    .WIDTH       (8),
    .DATA_W      (8),
    .ADDR_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (apb.slave),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [7:0] data,
                           output logic e, output logic [7:0] o_before);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = addr; apb.PWDATA = data;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    e = apb.PSLVERR;
    o_before = gpio_o;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [7:0] data, output logic e);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    data = apb.PRDATA;
    e = apb.PSLVERR;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0;
    gpio_i = 8'h00;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // reset state
    chk("rst_gpio_o", gpio_o, 8'h00);
    chk("rst_gpio_oe", gpio_oe, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_pready", apb.PREADY, 1'b1);
    chk("rst_pslverr", apb.PSLVERR, 1'b0);
    chk("rst_prdata", apb.PRDATA, 8'h00);
    for (int a = 0; a < 8; a++) begin
      apb_read(8'(a), rd, err);
      chk($sformatf("rst_read_%0d", a), rd, 8'h00);
      chk($sformatf("rst_err_%0d", a), err, 1'b0);
    end

    // OUT, OUT_SET, OUT_CLR with change on the edge ending ACCESS
    apb_write(8'h00, 8'h09, err, pre_o);
    chk("out_pre", pre_o, 8'h00);
    chk("out_post", gpio_o, 8'h09);
    apb_write(8'h06, 8'h06, err, pre_o);
    chk("set_pre", pre_o, 8'h09);
    chk("set_post", gpio_o, 8'h0F);
    apb_write(8'h07, 8'h01, err, pre_o);
    chk("clr_pre", pre_o, 8'h0F);
    chk("clr_post", gpio_o, 8'h0E);
    apb_read(8'h00, rd, err);
    chk("out_read", rd, 8'h0E);
    apb_read(8'h06, rd, err);
    chk("out_set_reads0", rd, 8'h00);
    apb_write(8'h01, 8'hF0, err, pre_o);
    chk("dir_oe", gpio_oe, 8'hF0);
    chk("dir_o_indep", gpio_o, 8'h0E);
    apb_write(8'h01, 8'h00, err, pre_o);
    chk("dir_oe_clear", gpio_oe, 8'h00);

    // rising edge on pin 0: latency to IN, IRQ_STAT and irq
    apb_write(8'h04, 8'h01, err, pre_o);
    apb_write(8'h03, 8'h01, err, pre_o);
    @(posedge PCLK); #1;                 // edge 0
    gpio_i = 8'h01;
    @(posedge PCLK); #1;                 // edge 1
    chk("lat_in_e1", dut.sync, 8'h00);
    @(posedge PCLK); #1;                 // edge 2
    chk("lat_in_e2", dut.sync, 8'h01);
    chk("lat_stat_e2", dut.irq_stat, 8'h00);
    @(posedge PCLK); #1;                 // edge 3
    chk("lat_stat_e3", dut.irq_stat, 8'h01);
    chk("lat_irq_e3", irq, 1'b0);
    @(posedge PCLK); #1;                 // edge 4
    chk("lat_irq_e4", irq, 1'b1);
    apb_read(8'h02, rd, err);
    chk("in_read", rd, 8'h01);
    apb_read(8'h05, rd, err);
    chk("stat_read", rd, 8'h01);
    apb_write(8'h05, 8'h01, err, pre_o);
    chk("w1c_stat", dut.irq_stat, 8'h00);
    chk("w1c_irq_hold", irq, 1'b1);
    @(posedge PCLK); #1;
    chk("w1c_irq_drop", irq, 1'b0);

    // falling edge on pin 3, masked, then enabled
    gpio_i = 8'h09;
    repeat (5) @(posedge PCLK);
    #1 chk("pin3_rise_noevt", dut.irq_stat, 8'h00);
    gpio_i = 8'h01;
    repeat (5) @(posedge PCLK);
    #1;
    apb_read(8'h05, rd, err);
    chk("pin3_fall_stat", rd, 8'h08);
    chk("pin3_masked_irq", irq, 1'b0);
    apb_write(8'h03, 8'h09, err, pre_o);
    chk("en_irq_pre", irq, 1'b0);
    @(posedge PCLK); #1;
    chk("en_irq_post", irq, 1'b1);
    apb_write(8'h05, 8'h08, err, pre_o);
    repeat (2) @(posedge PCLK);
    #1 chk("pin3_cleared_irq", irq, 1'b0);

    // W1C colliding with a new rising event on pin 0: set wins
    gpio_i = 8'h00;
    repeat (5) @(posedge PCLK);
    #1 chk("pin0_fall_noevt", dut.irq_stat, 8'h00);
    @(posedge PCLK); #1;                 // edge 0
    gpio_i = 8'h01;
    apb_write(8'h05, 8'h01, err, pre_o);  // commits on edge 3
    chk("collide_set_wins", dut.irq_stat, 8'h01);
    apb_write(8'h05, 8'h01, err, pre_o);
    chk("collide_then_clear", dut.irq_stat, 8'h00);

    // edges on an output pin are ignored
    apb_write(8'h01, 8'h02, err, pre_o);
    apb_write(8'h04, 8'h03, err, pre_o);
    gpio_i = 8'h03;
    repeat (5) @(posedge PCLK);
    #1;
    apb_read(8'h05, rd, err);
    chk("outpin_noevt", rd, 8'h00);

    // unmapped offset and write to read-only IN
    apb_write(8'h20, 8'hFF, err, pre_o);
    chk("unmap_wr_err", err, 1'b1);
    apb_read(8'h00, rd, err);
    chk("unmap_no_change", rd, 8'h0E);
    apb_read(8'h20, rd, err);
    chk("unmap_rd_data", rd, 8'h00);
    chk("unmap_rd_err", err, 1'b1);
    apb_write(8'h02, 8'hFF, err, pre_o);
    chk("ro_in_err", err, 1'b0);
    apb_read(8'h02, rd, err);
    chk("ro_in_value", rd, 8'h03);

    // reset during ACCESS of a write to OUT aborts it
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 8'h00; apb.PWDATA = 8'hAA;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    PRESETn = 1'b1;
    chk("rst_mid_gpio_o", gpio_o, 8'h00);
    chk("rst_mid_gpio_oe", gpio_oe, 8'h00);
    apb_read(8'h00, rd, err);
    chk("rst_mid_out", rd, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_gpio_irq.md
# apb_gpio_irq

Parametrised APB slave GPIO port, the next generation of the team's 8-bit `apb_gpio`. It adds:
- configurable pin count and data width;
- a per-pin direction register;
- atomic set/clear of output bits;
- an input synchronizer;
- per-pin edge-triggered interrupts with a sticky write-1-to-clear status and a single `irq` line.

It sits on the peripheral APB bus next to the other APB slaves.

## Interface
Parameters:
- `WIDTH`, 8, number of GPIO pins (1..DATA_W)
- `DATA_W`, 8, APB data width (8, 16 or 32)
- `ADDR_W`, 8, APB address width
- `SYNC_STAGES`, 2, input synchronizer flops (≥2)

Ports (one clock, `PCLK`; reset `PRESETn` is synchronous and active-low):
- `PCLK` in 1, bus and core clock
- `PRESETn` in 1, synchronous active-low reset, sampled on rising `PCLK`
- `PSEL` in 1, slave select
- `PENABLE` in 1, access phase
- `PADDR` in ADDR_W, byte-agnostic word index (register offset)
- `PWRITE` in 1, 1 = write
- `PWDATA` in DATA_W, write data
- `PRDATA` out DATA_W, read data
- `PREADY` out 1, transfer complete
- `PSLVERR` out 1, unmapped-address error
- `gpio_i` in WIDTH, asynchronous pin inputs
- `gpio_o` out WIDTH, pin output values
- `gpio_oe` out WIDTH, pin output enables (1 = drive)
- `irq` out 1, level interrupt

## Operation
Register map (offset, access, reset value):
- 0x00 `OUT`, RW, 0
- 0x01 `DIR`, RW, 0 (1 = output; drives `gpio_oe`)
- 0x02 `IN`, RO, synchronized `gpio_i`
- 0x03 `IRQ_EN`, RW, 0
- 0x04 `IRQ_POL`, RW, 0 (1 = rising edge, 0 = falling edge)
- 0x05 `IRQ_STAT`, RW1C, 0
- 0x06 `OUT_SET`, WO, reads 0: `OUT |= PWDATA`
- 0x07 `OUT_CLR`, WO, reads 0: `OUT &= ~PWDATA`

Register rules:
- Only bits [WIDTH-1:0] are stored. Upper `PWDATA` bits are ignored; upper `PRDATA` bits read 0.
- `gpio_o = OUT`; `gpio_oe = DIR`. `gpio_o` is independent of `DIR`.

Edge detection and status:
- Per bit, `sync` is the synchronizer output and `prev` is `sync` delayed one cycle.
- `event = POL ? (sync & ~prev) : (~sync & prev)`, qualified by `~DIR` (input pins only).
- An event sets the `IRQ_STAT` bit regardless of `IRQ_EN`.
- An `IRQ_STAT` bit clears only on a W1C write to 0x05 with the bit = 1.
- If a W1C and a new event hit the same bit in the same cycle, the set wins.
- Writing `IRQ_EN` or `IRQ_POL` never modifies `IRQ_STAT`.
- `prev` is loaded from `sync` every cycle, including the cycle `POL` changes, so a polarity change produces no spurious event.

Interrupt and errors:
- `irq` is registered: `irq <= |(IRQ_STAT & IRQ_EN)`.
- Unmapped offset (> 0x07): write is ignored, `PRDATA` = 0, `PSLVERR` = 1 in the access phase.
- A write to RO `IN` is ignored with `PSLVERR` = 0.

Reset: all registers, synchronizer flops, `prev`, `PRDATA`, `PSLVERR` and `irq` are 0. `PREADY` is 1. Reset asserted mid-transfer aborts the transfer with no register update.

## Timing
APB handshake:
- `PREADY` is tied 1: zero wait states.
- A transfer is SETUP (`PSEL & ~PENABLE`) then ACCESS (`PSEL & PENABLE`).
- Writes commit on the rising `PCLK` that ends ACCESS. `gpio_o`/`gpio_oe` change on that same edge.
- `PRDATA` and `PSLVERR` are registered during SETUP (address decoded from the SETUP-phase `PADDR`) and held stable through ACCESS.
- `PRDATA` holds its last value when idle.
- A read of `IRQ_STAT` in the same cycle as a set returns the pre-set value.

Input-to-interrupt latency, with a `gpio_i` change sampled at edge 0:
- `IN` reflects it after `SYNC_STAGES` edges.
- `IRQ_STAT` sets at edge `SYNC_STAGES+1`.
- `irq` asserts at edge `SYNC_STAGES+2`.
- After a W1C, `irq` deasserts one edge after `IRQ_STAT` clears.

Back-to-back transfers (ACCESS followed immediately by SETUP) are supported.

## Structure
- Package `apb_gpio_pkg`: register offset constants (`GPIO_OUT` … `GPIO_OUT_CLR`), `GPIO_NREGS` = 8.
- Sub-module `gpio_sync_edge` (param `WIDTH`, `SYNC_STAGES`), one instance: synchronizer chain plus `prev` register. Outputs `sync` and per-bit `rise` and `fall`; the top selects between them using `POL`.
- Top `apb_gpio_irq` holds the APB decode, register file and interrupt logic.

## Test plan
1. Reset then read 0x00..0x07 → all `PRDATA` = 0, `gpio_o` = `gpio_oe` = 0, `irq` = 0, `PREADY` = 1.
2. Write `OUT` = 0x09, then `OUT_SET` 0x06, then `OUT_CLR` 0x01 → `gpio_o` = 0x09, 0x0F, 0x0E, each changing on the edge ending ACCESS.
3. `DIR` = 0x00, `IRQ_POL` = 0x01, `IRQ_EN` = 0x01, `gpio_i[0]` 0→1 at edge 0 → `IN[0]` = 1 at edge 2, `IRQ_STAT` = 0x01 at edge 3, `irq` = 1 at edge 4. W1C 0x01 → `irq` = 0 two edges later.
4. Falling-edge pin 3 (`POL[3]` = 0) with `IRQ_EN[3]` = 0 → `IRQ_STAT` = 0x08, `irq` stays 0. Then set `IRQ_EN` = 0x08 → `irq` = 1 after one edge.
5. W1C of bit 0 in the same cycle as a new rising event on pin 0 → `IRQ_STAT[0]` remains 1. An event on a pin with `DIR` = 1 → no status change.
6. Read/write offset 0x20 → `PSLVERR` = 1, `PRDATA` = 0, no register change. Reset asserted during ACCESS of a write to `OUT` → `OUT` = 0.
